// File: rtl/spi_seq_pkg.sv
// Shared constants and FSM state type for the simple_spi Wishbone sequencer.
package spi_seq_pkg;

  // simple_spi register map
  localparam logic [2:0] AdrSpcr = 3'd0;
  localparam logic [2:0] AdrSpsr = 3'd1;
  localparam logic [2:0] AdrSpdr = 3'd2;
  localparam logic [2:0] AdrSper = 3'd3;
  localparam logic [2:0] AdrSsr  = 3'd4;

  localparam int unsigned SpifBit = 7;

  typedef enum logic [3:0] {
    StCfgSpcr,
    StCfgSper,
    StIdle,
    StSsOn,
    StWrDat,
    StPoll,
    StClrIf,
    StRdDat,
    StRsp,
    StSsOff
  } seq_state_e;

endpackage

// File: rtl/spi_wb_sequencer_wb_single_master.sv
// Wishbone B3 classic single-access master: one request in, one done pulse out.
module wb_single_master (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] wdat_i,
  output logic       done_o,
  output logic [7:0] rdat_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  logic       cyc_q, cyc_d;
  logic       we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;

  // Ack only counts while our strobe is up; read data is valid alongside done.
  assign done_o = cyc_q & wb_ack_i;
  assign rdat_o = wb_dat_i;

  // Start an access when idle; drop the cycle on ack, which forces one idle cycle.
  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (cyc_q) begin
      if (wb_ack_i) cyc_d = 1'b0;
    end else if (req_i) begin
      cyc_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = wdat_i;
    end
  end

  // Bus registers; reset drops the cycle asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= 3'd0;
      dat_q <= 8'h00;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: rtl/spi_wb_sequencer.sv
// Sequences simple_spi register accesses: post-reset configuration, then one
// byte per command with SPIF polling, framed by slave-select writes.
module spi_wb_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned          SS_WIDTH  = 1,
  parameter logic [7:0]           SPCR_INIT = 8'h58,
  parameter logic [7:0]           SPER_INIT = 8'h02,
  parameter logic [SS_WIDTH-1:0]  SS_MASK   = 1,
  parameter int unsigned          POLL_MAX  = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_last_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic       busy_o,
  output logic       cfg_done_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  localparam int unsigned CntW = $clog2(POLL_MAX + 1);

  seq_state_e state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic            open_q, open_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            cfg_done_q, cfg_done_d;

  logic       req, we, done;
  logic [2:0] adr;
  logic [7:0] wdat, rdat;

  wb_single_master u_wb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .we_i     (we),
    .adr_i    (adr),
    .wdat_i   (wdat),
    .done_o   (done),
    .rdat_o   (rdat),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  assign cnt_inc = cnt_q + CntW'(1);

  // Next state, bus request and datapath updates; transitions happen on access done.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    last_d     = last_q;
    open_d     = open_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cfg_done_d = cfg_done_q;
    req        = 1'b0;
    we         = 1'b0;
    adr        = AdrSpcr;
    wdat       = 8'h00;
    unique case (state_q)
      StCfgSpcr: begin
        req = 1'b1; we = 1'b1; adr = AdrSpcr; wdat = SPCR_INIT;
        if (done) state_d = StCfgSper;
      end
      StCfgSper: begin
        req = 1'b1; we = 1'b1; adr = AdrSper; wdat = SPER_INIT;
        if (done) begin
          cfg_done_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StIdle: begin
        if (cmd_valid_i) begin
          data_d  = cmd_data_i;
          last_d  = cmd_last_i;
          state_d = open_q ? StWrDat : StSsOn;
        end
      end
      StSsOn: begin
        req = 1'b1; we = 1'b1; adr = AdrSsr; wdat = 8'(SS_MASK);
        if (done) begin
          open_d  = 1'b1;
          state_d = StWrDat;
        end
      end
      StWrDat: begin
        req = 1'b1; we = 1'b1; adr = AdrSpdr; wdat = data_q;
        if (done) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StPoll;
        end
      end
      StPoll: begin
        req = 1'b1; adr = AdrSpsr;
        if (done) begin
          cnt_d = cnt_inc;
          if (rdat[SpifBit]) begin
            state_d = StClrIf;
          end else if (cnt_inc == CntW'(POLL_MAX)) begin
            // Give up on this byte; the counter stops here so it never wraps.
            err_d   = 1'b1;
            state_d = StClrIf;
          end
        end
      end
      StClrIf: begin
        req = 1'b1; we = 1'b1; adr = AdrSpsr; wdat = 8'h80;
        if (done) state_d = StRdDat;
      end
      StRdDat: begin
        req = 1'b1; adr = AdrSpdr;
        if (done) begin
          rsp_data_d = rdat;
          rsp_err_d  = err_q;
          state_d    = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready_i) state_d = (last_q || err_q) ? StSsOff : StIdle;
      end
      StSsOff: begin
        req = 1'b1; we = 1'b1; adr = AdrSsr; wdat = 8'h00;
        if (done) begin
          open_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StCfgSpcr;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StCfgSpcr;
      data_q     <= 8'h00;
      last_q     <= 1'b0;
      open_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      last_q     <= last_d;
      open_q     <= open_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StRsp);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign cfg_done_o  = cfg_done_q;
  // Busy reflects command processing only, so it stays low during configuration.
  assign busy_o      = cfg_done_q && (state_q != StIdle);

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Scoreboard bench: a simple_spi slave model with random wait states and SPIF
// delays, an expected-access queue and an expected-response queue.
module tb_spi_wb_sequencer;

  localparam int unsigned PollMax = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [7:0] cmd_data_i = 8'h00;
  logic       cmd_last_i = 1'b0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [7:0] rsp_data_o;
  logic       rsp_err_o;
  logic       busy_o;
  logic       cfg_done_o;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;

  spi_wb_sequencer #(
    .SS_WIDTH  (1),
    .SPCR_INIT (8'h58),
    .SPER_INIT (8'h02),
    .SS_MASK   (1'b1),
    .POLL_MAX  (PollMax)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_data_i  (cmd_data_i),
    .cmd_last_i  (cmd_last_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o),
    .cfg_done_o  (cfg_done_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } wb_t;

  typedef struct packed {
    logic       err;
    logic [7:0] dat;
  } rsp_t;

  wb_t         exp_wb[$];
  rsp_t        exp_rsp[$];
  int unsigned plan_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          frame_open = 1'b0;
  bit          hold = 1'b0;
  int          force_ws = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic wb_t mk(input logic we, input logic [2:0] adr, input logic [7:0] dat);
    wb_t t;
    t.we  = we;
    t.adr = adr;
    t.dat = dat;
    return t;
  endfunction

  // ---------------- simple_spi slave model ----------------
  int unsigned ws_cur, wait_cnt, sr_reads, k_cur;
  logic [7:0]  spdr;
  logic        spif_now;

  assign wb_ack_i = wb_cyc_o && wb_stb_o && (wait_cnt == ws_cur);
  assign spif_now = (sr_reads + 1 >= k_cur);
  assign wb_dat_i = (wb_adr_o == 3'd1) ? {spif_now, 7'b0} :
                    (wb_adr_o == 3'd2) ? spdr : 8'h00;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= 0;
      ws_cur   <= 0;
      sr_reads <= 0;
      k_cur    <= 1;
      spdr     <= 8'h00;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (wb_ack_i) begin
        wait_cnt <= 0;
        ws_cur   <= (force_ws >= 0) ? force_ws : $urandom_range(0, 2);
        if (wb_we_o && wb_adr_o == 3'd2) begin
          spdr     <= wb_dat_o;
          sr_reads <= 0;
          if (plan_q.size() > 0) begin
            k_cur <= plan_q[0];
            plan_q.delete(0);
          end
        end else if (!wb_we_o && wb_adr_o == 3'd1) begin
          sr_reads <= sr_reads + 1;
        end else if (wb_we_o && wb_adr_o == 3'd1 && wb_dat_o[7]) begin
          sr_reads <= 0;
          k_cur    <= 32'h4000_0000;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // ---------------- monitors ----------------
  logic gap_pending = 1'b0;
  logic hold_pend = 1'b0;
  rsp_t held;

  // Wishbone access monitor: every completed access must match the next expectation.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (gap_pending) check("wb_idle_gap", {31'b0, wb_cyc_o}, 0);
      if (wb_ack_i) begin
        if (exp_wb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected: got we=%0b adr=%0d dat=%0h expected none",
                   wb_we_o, wb_adr_o, wb_dat_o);
        end else begin
          wb_t e;
          e = exp_wb.pop_front();
          check("wb_we", {31'b0, wb_we_o}, {31'b0, e.we});
          check("wb_adr", {29'b0, wb_adr_o}, {29'b0, e.adr});
          if (e.we) check("wb_wdat", {24'b0, wb_dat_o}, {24'b0, e.dat});
        end
      end
      gap_pending <= wb_ack_i;
    end else begin
      gap_pending <= 1'b0;
    end
  end

  // Response monitor: ordering, content and stability while stalled.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (hold_pend) begin
        check("rsp_valid_stable", {31'b0, rsp_valid_o}, 1);
        check("rsp_data_stable", {23'b0, rsp_err_o, rsp_data_o}, {23'b0, held});
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got %0h expected none", rsp_data_o);
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          check("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
          if (!e.err) check("rsp_data", {24'b0, rsp_data_o}, {24'b0, e.dat});
        end
      end
      hold_pend <= rsp_valid_o && !rsp_ready_i;
      held      <= {rsp_err_o, rsp_data_o};
    end else begin
      hold_pend <= 1'b0;
    end
  end

  // Random response backpressure, or a full stall while hold is set.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      rsp_ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model + stimulus ----------------
  // k is the status read on which SPIF shows up; k > PollMax means it never does in time.
  task automatic send_byte(input logic [7:0] b, input logic last, input int unsigned k);
    bit err;
    int n;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b1;
    cmd_data_i  = b;
    cmd_last_i  = last;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!cmd_ready_o && n < 5000);
    if (!cmd_ready_o) begin
      check("cmd_ready_timeout", {31'b0, cmd_ready_o}, 1);
      cmd_valid_i = 1'b0;
      return;
    end
    err = (k > PollMax);
    if (!frame_open) begin
      exp_wb.push_back(mk(1'b1, 3'd4, 8'h01));
      frame_open = 1'b1;
    end
    plan_q.push_back(k);
    exp_wb.push_back(mk(1'b1, 3'd2, b));
    for (int i = 0; i < (err ? PollMax : k); i++) exp_wb.push_back(mk(1'b0, 3'd1, 8'h00));
    exp_wb.push_back(mk(1'b1, 3'd1, 8'h80));
    exp_wb.push_back(mk(1'b0, 3'd2, 8'h00));
    exp_rsp.push_back({err, b});
    if (last || err) begin
      exp_wb.push_back(mk(1'b1, 3'd4, 8'h00));
      frame_open = 1'b0;
    end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_wb.size() != 0 || exp_rsp.size() != 0) && n < 20000) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_wb_left"}, exp_wb.size(), 0);
    check({name, "_rsp_left"}, exp_rsp.size(), 0);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!cmd_ready_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_ready"}, {31'b0, cmd_ready_o}, 1);
    check({name, "_cfg_done"}, {31'b0, cfg_done_o}, 1);
  endtask

  initial begin
    int n;
    #1;
    check("rst_cyc", {31'b0, wb_cyc_o}, 0);
    check("rst_stb", {31'b0, wb_stb_o}, 0);
    check("rst_cmd_ready", {31'b0, cmd_ready_o}, 0);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 0);
    check("rst_busy", {31'b0, busy_o}, 0);
    check("rst_cfg_done", {31'b0, cfg_done_o}, 0);
    check("rst_wb_bus", {20'b0, wb_we_o, wb_adr_o, wb_dat_o}, 0);
    exp_wb.push_back(mk(1'b1, 3'd0, 8'h58));
    exp_wb.push_back(mk(1'b1, 3'd3, 8'h02));
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    wait_ready("cfg");
    check("cfg_writes_left", exp_wb.size(), 0);

    // Single byte, then a three-byte frame.
    send_byte(8'hA5, 1'b1, 2);
    wait_drain("single");
    send_byte(8'h01, 1'b0, 1);
    send_byte(8'h02, 1'b0, 3);
    send_byte(8'h03, 1'b1, 4);
    wait_drain("frame3");

    // Response stalled for 50 cycles: no bus activity, no new commands.
    hold = 1'b1;
    send_byte(8'h5A, 1'b1, 2);
    n = 0;
    while (!rsp_valid_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check("hold_rsp_valid", {31'b0, rsp_valid_o}, 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      check("hold_cmd_ready", {31'b0, cmd_ready_o}, 0);
      check("hold_wb_idle", {31'b0, wb_cyc_o}, 0);
    end
    hold = 1'b0;
    wait_drain("hold");

    // SPIF never arrives: timeout mid-frame closes the frame.
    send_byte(8'hC3, 1'b0, 1000);
    wait_drain("timeout");

    // Random frames with occasional timeouts.
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        send_byte(8'($urandom), (i == len - 1),
                  ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(1, 6));
      end
    end
    wait_drain("random");

    // Reset while a 3-wait-state status read is outstanding.
    force_ws = 3;
    send_byte(8'h3C, 1'b1, 1000);
    n = 0;
    while (!(wb_cyc_o && !wb_we_o && wb_adr_o == 3'd1 && !wb_ack_i) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check("midpoll_reached", {31'b0, wb_cyc_o}, 1);
    rst_ni = 1'b0;
    #1;
    check("midpoll_rst_cyc", {31'b0, wb_cyc_o}, 0);
    check("midpoll_rst_stb", {31'b0, wb_stb_o}, 0);
    check("midpoll_rst_cfg_done", {31'b0, cfg_done_o}, 0);
    exp_wb.delete();
    exp_rsp.delete();
    plan_q.delete();
    frame_open = 1'b0;
    force_ws = -1;
    exp_wb.push_back(mk(1'b1, 3'd0, 8'h58));
    exp_wb.push_back(mk(1'b1, 3'd3, 8'h02));
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    wait_ready("recfg");
    check("recfg_writes_left", exp_wb.size(), 0);
    send_byte(8'h96, 1'b1, 2);
    wait_drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_wb_sequencer.md
Name: spi_wb_sequencer

Overview:
- Wishbone B3 classic single-master controller that drives the 8-bit register interface of the simple_spi master.
- At start-up it programs the SPI configuration registers: SPCR (adr 0) and SPER (adr 3).
- It then turns a byte-stream command interface into complete SPI frames. Per byte: assert SSR (adr 4), write SPDR (adr 2), poll SPSR.SPIF (adr 1, bit 7), clear SPIF, read back SPDR. At frame end it releases SSR.
- It sits between a host-side requester and the simple_spi instance and removes all software polling.

Parameters:
- SS_WIDTH, 1, width of the simple_spi slave-select register
- SPCR_INIT, 8'h58, SPCR value written after reset (SPE=1, MSTR=1, CPOL=1)
- SPER_INIT, 8'h02, SPER value written after reset
- SS_MASK, 1, SSR value written while a frame is open
- POLL_MAX, 1024, maximum SPSR reads per byte before timeout

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active low
- cmd_valid_i  in  1  command byte valid
- cmd_ready_o  out  1  command byte accepted when valid&ready
- cmd_data_i  in  8  byte to transmit
- cmd_last_i  in  1  last byte of frame; SS is released after it
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_data_o  out  8  byte received from SPDR
- rsp_err_o  out  1  SPIF poll timeout on this byte
- busy_o  out  1  not in IDLE
- cfg_done_o  out  1  post-reset configuration finished
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  3  register address
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_ack_i  in  1  acknowledge

Behaviour:
- Reset (rst_ni=0, effective immediately, no clock required):
  - cyc, stb, we all 0; adr=0; wb_dat_o=0.
  - cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0, cfg_done=0.
  - State = CFG_SPCR.
  - Reset during a Wishbone cycle drops cyc/stb immediately. The frame is abandoned and SS is not restored by this block.
- Wishbone access primitive:
  - Drive cyc=stb=1 with adr/we/dat until the cycle where wb_ack_i=1. On an ack to a read, capture wb_dat_i.
  - The next cycle always has cyc=stb=0 (one idle cycle between accesses).
  - Minimum access is 2 cycles. Wait states are unbounded.
  - An ack while stb=0 is ignored.
- FSM:
  - CFG_SPCR: write SPCR_INIT to adr 0 → CFG_SPER.
  - CFG_SPER: write SPER_INIT to adr 3 → IDLE, set cfg_done=1 (sticky until reset).
  - IDLE: cmd_ready=1, busy=0. On valid&ready, latch data and last.
    - If no frame is open → SS_ON.
    - If a frame is open → WR_DAT.
  - SS_ON: write SS_MASK (zero-extended to 8 bits) to adr 4, mark frame open → WR_DAT.
  - WR_DAT: write the latched byte to adr 2; clear the poll counter → POLL.
  - POLL: read adr 1, increment the poll counter.
    - If bit7=1 → CLR_IF.
    - Else if counter==POLL_MAX → CLR_IF with err=1.
    - Else → POLL.
  - CLR_IF: write 8'h80 to adr 1 → RD_DAT.
  - RD_DAT: read adr 2 into rsp_data → RSP. rsp_err=err.
    - On timeout the read is still performed; the data is don't-care.
  - RSP: rsp_valid=1, with data/err held stable until rsp_ready.
    - On handshake: if the latched last=1 or err=1 → SS_OFF; else → IDLE.
  - SS_OFF: write 8'h00 to adr 4, mark frame closed → IDLE.
- Handshake rules:
  - cmd_ready is high only in IDLE, so at most one byte is in flight.
  - rsp_valid must not drop without rsp_ready.
- Poll counter: width $clog2(POLL_MAX+1). It must never wrap.
- Latency: with zero-wait-state ack, one byte costs 2 cycles per access, plus the poll count and the response handshake.

Decomposition:
- Package spi_seq_pkg holds:
  - Register address constants: SPCR=3'd0, SPSR=3'd1, SPDR=3'd2, SPER=3'd3, SSR=3'd4.
  - SPIF_BIT=7.
  - FSM state enum: CFG_SPCR, CFG_SPER, IDLE, SS_ON, WR_DAT, POLL, CLR_IF, RD_DAT, RSP, SS_OFF.
- One sub-module, wb_single_master, owns the Wishbone access primitive. Its interface is req/we/adr/wdat in and done/rdat out.

Test Plan:
- Reset release with a zero-wait simple_spi → exactly two writes: adr0=8'h58, then adr3=8'h02. cfg_done rises after the second ack; cmd_ready=1.
- Single byte 8'hA5 with last=1 and MISO looped to MOSI. Required write sequence: adr4=8'h01, adr2=8'hA5, polls of adr1, adr1=8'h80, read adr2, adr4=8'h00. rsp_data=8'hA5, rsp_err=0.
- Three-byte frame 8'h01/8'h02/8'h03 with last only on the third byte → SSR is written once at the start and once at the end. Three responses arrive in order.
- Hold rsp_ready=0 for 50 cycles → rsp_valid/data stay stable, cmd_ready=0, and no Wishbone activity occurs.
- Slave model that never sets SPIF, with POLL_MAX=8 → exactly 8 reads of adr1, then 8'h80 written to adr1, an adr2 read, a response with rsp_err=1, and SS released.
- Assert rst_ni mid-POLL while a 3-wait-state ack is pending → cyc/stb drop in the same cycle. After release, configuration restarts with the SPCR write.
